// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared definitions for the gm64 memory-controller request
// interface. Used by mem_responder and by the initiator-side FSM.
//   mem_state_e  : responder state encoding (INIT, IDLE, WAIT, ACCESS)
//   MEMIF_ADDR_W : width of the initiator byte address
//   LFSR_SEED / LFSR_TAPS / lfsr_next : 8-bit Fibonacci LFSR (taps 8,6,5,4)
package mem_if_pkg;

  typedef enum bit [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } mem_state_e;

  localparam int         MEMIF_ADDR_W = 24;
  localparam logic [7:0] LFSR_SEED    = 8'hA5;
  // Bits 7,5,4,3 correspond to taps 8,6,5,4.
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// mem_responder_ram: single-port synchronous block RAM, 2^AW x 8.
// The read port is registered every cycle from i_addr, so the data for a
// stable address is available one edge later. Contents are never reset.
//   clkSys   in   clock
//   i_we     in   write enable (commits i_wdata at i_addr on the edge)
//   i_addr   in   word address
//   i_wdata  in   write data
//   o_rdata  out  registered read data (read-before-write)
module mem_responder_ram #(
  parameter int AW = 13
) (
  input  logic          clkSys,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] mem_q [2**AW];
  logic [7:0] rdata_q;

  always_ff @(posedge clkSys) begin
    if (i_we) mem_q[i_addr] <= i_wdata;
    rdata_q <= mem_q[i_addr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: block-RAM backed stand-in for the PSRAM memory controller.
// Accepts one request per i_cs low period (re-armed by i_cs high), waits
// LATENCY cycles, then performs the RAM access and drops o_busy.
// Optional macro MEM_RESPONDER_JITTER_EN adds 0..3 random wait cycles per
// access from an 8-bit LFSR.
//   clkSys         in   system clock
//   rst            in   asynchronous reset, active-low
//   i_cs           in   request select, active-low
//   i_write        in   1 = write, 0 = read
//   i_address      in   24-bit byte address
//   i_bank         in   bank select (internal address MSB)
//   i_dataToWrite  in   write data
//   o_dataRead     out  read data, valid while o_dataReady
//   o_busy         out  cannot accept a request
//   o_dataReady    out  read completed
//   o_addrErr      out  sticky: accepted address exceeded ADDR_W bits
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int LATENCY     = 4,
  parameter int INIT_CYCLES = 16
) (
  input  logic                    clkSys,
  input  logic                    rst,
  input  logic                    i_cs,
  input  logic                    i_write,
  input  logic [MEMIF_ADDR_W-1:0] i_address,
  input  logic                    i_bank,
  input  logic [7:0]              i_dataToWrite,
  output logic [7:0]              o_dataRead,
  output logic                    o_busy,
  output logic                    o_dataReady,
  output logic                    o_addrErr
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int CNT_W  = (INIT_W > 5) ? INIT_W : 5;

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             write_q, write_d;
  logic [ADDR_W:0]  addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       dataRead_q, dataRead_d;
  logic             dataReady_q, dataReady_d;
  logic             addrErr_q, addrErr_d;
  logic             ram_we;
  logic [7:0]       ram_rdata;
  logic [CNT_W-1:0] wait_load;

`ifdef MEM_RESPONDER_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign wait_load = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
  assign wait_load = CNT_W'(LATENCY);
`endif

  always_ff @(posedge clkSys or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= CNT_W'(INIT_CYCLES - 1);
      armed_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      dataRead_q  <= 8'h00;
      dataReady_q <= 1'b0;
      addrErr_q   <= 1'b0;
`ifdef MEM_RESPONDER_JITTER_EN
      lfsr_q      <= LFSR_SEED;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      dataRead_q  <= dataRead_d;
      dataReady_q <= dataReady_d;
      addrErr_q   <= addrErr_d;
`ifdef MEM_RESPONDER_JITTER_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    // Any edge with i_cs high re-arms; acceptance below clears it.
    armed_d     = armed_q | i_cs;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dataRead_d  = dataRead_q;
    dataReady_d = dataReady_q;
    addrErr_d   = addrErr_q;
    ram_we      = 1'b0;
`ifdef MEM_RESPONDER_JITTER_EN
    lfsr_d      = lfsr_q;
`endif
    case (state_q)
      ST_INIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_IDLE: begin
        if (!i_cs && armed_q) begin
          write_d     = i_write;
          addr_d      = {i_bank, i_address[ADDR_W-1:0]};
          wdata_d     = i_dataToWrite;
          armed_d     = 1'b0;
          dataReady_d = 1'b0;
          cnt_d       = wait_load;
          state_d     = ST_WAIT;
          if (i_address[MEMIF_ADDR_W-1:ADDR_W] != '0) addrErr_d = 1'b1;
`ifdef MEM_RESPONDER_JITTER_EN
          lfsr_d      = lfsr_next(lfsr_q);
`endif
        end
      end
      // Terminal count at zero costs one extra edge, which together with the
      // ACCESS edge gives LATENCY+2 busy cycles after acceptance.
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ACCESS: begin
        ram_we = write_q;
        if (!write_q) begin
          // addr_q has been stable since acceptance, so ram_rdata is current.
          dataRead_d  = ram_rdata;
          dataReady_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  mem_responder_ram #(
    .AW (ADDR_W + 1)
  ) u_ram (
    .clkSys  (clkSys),
    .i_we    (ram_we),
    .i_addr  (addr_q),
    .i_wdata (wdata_q),
    .o_rdata (ram_rdata)
  );

  assign o_busy      = (state_q != ST_IDLE);
  assign o_dataRead  = dataRead_q;
  assign o_dataReady = dataReady_q;
  assign o_addrErr   = addrErr_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder with a
// behavioural memory model (byte array + sticky error flag).
module tb_mem_responder;

  localparam int ADDR_W  = 12;
  localparam int LATENCY = 4;
  localparam int INIT_C  = 16;

  logic        clkSys = 1'b0;
  logic        rst = 1'b0;
  logic        i_cs = 1'b1;
  logic        i_write = 1'b0;
  logic [23:0] i_address = '0;
  logic        i_bank = 1'b0;
  logic [7:0]  i_dataToWrite = '0;
  logic [7:0]  o_dataRead;
  logic        o_busy;
  logic        o_dataReady;
  logic        o_addrErr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem_m   [2**(ADDR_W+1)];
  bit         known_m [2**(ADDR_W+1)];
  bit         err_m = 0;
  bit         seen_len [16];
  int         written_q [$];

  always #5 clkSys = ~clkSys;

  mem_responder #(
    .ADDR_W(ADDR_W), .LATENCY(LATENCY), .INIT_CYCLES(INIT_C)
  ) dut (
    .clkSys(clkSys), .rst(rst), .i_cs(i_cs), .i_write(i_write),
    .i_address(i_address), .i_bank(i_bank), .i_dataToWrite(i_dataToWrite),
    .o_dataRead(o_dataRead), .o_busy(o_busy), .o_dataReady(o_dataReady),
    .o_addrErr(o_addrErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Holds reset for a few cycles, checks reset outputs, then measures INIT.
  task automatic reset_and_init();
    int n;
    bit done;
    rst  = 1'b0;
    i_cs = 1'b1;
    err_m = 0;
    repeat (3) @(negedge clkSys);
    check("rst_busy", o_busy, 1);
    check("rst_ready", o_dataReady, 0);
    check("rst_data", o_dataRead, 8'h00);
    check("rst_err", o_addrErr, 0);
    rst = 1'b1;
    n = 0;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge clkSys); #1;
      n++;
      if (!o_busy) done = 1;
    end
    check("init_len", n, INIT_C);
  endtask

  // One complete request. i_cs is held low for hold_extra extra cycles after
  // completion to prove no second access is accepted.
  task automatic access(input bit wr, input logic [23:0] addr, input bit bank,
                        input logic [7:0] data, input int hold_extra);
    int n;
    bit done;
    bit reacc;
    int idx;
    @(negedge clkSys);
    i_cs = 1'b1;
    @(negedge clkSys);
    i_write = wr; i_address = addr; i_bank = bank; i_dataToWrite = data;
    i_cs = 1'b0;
    n = 0;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clkSys); #1;
      if (k == 0) begin
        // Scramble inputs after acceptance; they must not matter.
        i_write = ~wr; i_address = $urandom; i_bank = ~bank; i_dataToWrite = ~data;
      end
      if (o_busy) n++;
      else done = 1;
    end
    idx = {bank, addr[ADDR_W-1:0]};
    if (addr[23:ADDR_W] != '0) err_m = 1;
    if (wr) begin
      mem_m[idx] = data;
      known_m[idx] = 1;
    end
`ifdef MEM_RESPONDER_JITTER_EN
    check("busy_len_range", (n >= LATENCY + 2 && n <= LATENCY + 5), 1);
    if (n < 16) seen_len[n] = 1;
`else
    check("busy_len", n, LATENCY + 2);
`endif
    check("ready", o_dataReady, !wr);
    if (!wr && known_m[idx]) check("rdata", o_dataRead, mem_m[idx]);
    check("addr_err", o_addrErr, err_m);
    if (hold_extra > 0) begin
      reacc = 0;
      repeat (hold_extra) begin
        @(posedge clkSys); #1;
        if (o_busy) reacc = 1;
      end
      check("no_reaccept", reacc, 0);
    end
    @(negedge clkSys);
    i_cs = 1'b1;
  endtask

  initial begin
    int nlen;
    int idx;
    bit done;
    bit busy_seen;
    logic [23:0] a;

    reset_and_init();

    // Held-low write produces one access; then read back.
    access(1, 24'h000001, 1, 8'hAA, 20);
    access(0, 24'h000001, 1, 8'h00, 0);

    // Bank separation; write after read clears dataReady.
    access(1, 24'h000001, 0, 8'h55, 0);
    access(0, 24'h000001, 0, 8'h00, 0);
    access(0, 24'h000001, 1, 8'h00, 0);
    access(1, 24'h000002, 0, 8'h12, 0);

    // Out-of-range address wraps and sets sticky error.
    access(1, 24'h001005, 0, 8'h3C, 0);
    access(0, 24'h000005, 0, 8'h00, 0);
    check("err_sticky", o_addrErr, 1);

    // i_cs pulses while busy are ignored.
    @(negedge clkSys);
    i_write = 0; i_address = 24'h000001; i_bank = 1; i_cs = 0;
    @(posedge clkSys); #1;
    check("pulse_accept", o_busy, 1);
    @(negedge clkSys); i_cs = 1;
    @(negedge clkSys); i_cs = 0; i_address = 24'h000002; i_bank = 0;
    @(negedge clkSys); i_cs = 1;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clkSys); #1;
      if (!o_busy) done = 1;
    end
    check("pulse_done", done, 1);
    busy_seen = 0;
    repeat (4) begin
      @(posedge clkSys); #1;
      if (o_busy) busy_seen = 1;
    end
    check("pulse_no_queue", busy_seen, 0);
    check("pulse_rdata", o_dataRead, 8'hAA);

    // Reset in the second WAIT cycle of a write: not committed.
    @(negedge clkSys);
    i_write = 1; i_address = 24'h000002; i_bank = 0; i_dataToWrite = 8'h77; i_cs = 0;
    @(posedge clkSys);
    @(posedge clkSys); #1;
    check("midwait_busy", o_busy, 1);
    reset_and_init();
    access(0, 24'h000002, 0, 8'h00, 0);
    check("midwait_old", o_dataRead, 8'h12);

    // Randomized traffic: 64 writes interleaved with 64 reads.
    for (int i = 0; i < 128; i++) begin
      if (i % 2 == 0) begin
        a = 24'($urandom_range(0, 2**ADDR_W - 1));
        if ($urandom_range(0, 3) == 0) a[23:ADDR_W] = 12'($urandom_range(1, 4095));
        idx = $urandom_range(0, 1);
        access(1, a, idx[0], 8'($urandom), 0);
        written_q.push_back({idx[0], a[ADDR_W-1:0]});
      end else begin
        idx = written_q[$urandom_range(0, written_q.size() - 1)];
        a = 24'(idx[ADDR_W-1:0]);
        access(0, a, idx[ADDR_W], 8'h00, 0);
      end
    end

`ifdef MEM_RESPONDER_JITTER_EN
    nlen = 0;
    for (int k = 0; k < 16; k++) if (seen_len[k]) nlen++;
    check("jitter_distinct", (nlen >= 2), 1);
`else
    nlen = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable responder for the memory-controller request interface used by gm64 initiators (RAM test FSM, CPU glue, VIC fetch).
- Backs requests with on-chip block RAM and programmable wait states. It is a drop-in stand-in for the PSRAM memory controller, for bring-up and simulation without PSRAM.
- Implements the same chip-select, busy and dataReady handshake the initiators already drive.

Parameters:
- ADDR_W, 12: internal address bits per bank; depth per bank is 2^ADDR_W bytes.
- LATENCY, 4: wait cycles per access; legal range 1..15.
- INIT_CYCLES, 16: power-up busy period after reset release, mimicking PSRAM init.

Ports:
- clkSys  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- i_cs  input  1  request select, active-low.
- i_write  input  1  1 = write, 0 = read; sampled at acceptance.
- i_address  input  24  byte address; sampled at acceptance.
- i_bank  input  1  bank select; forms the internal address MSB.
- i_dataToWrite  input  8  write data; sampled at acceptance.
- o_dataRead  output  8  read data; valid while o_dataReady=1.
- o_busy  output  1  responder cannot accept a request.
- o_dataReady  output  1  read completed, data valid.
- o_addrErr  output  1  sticky flag: an accepted address had bits above ADDR_W-1 set.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=INIT, o_busy=1, o_dataReady=0, o_dataRead=8'h00, o_addrErr=0, armed=0.
  - RAM contents are not cleared.
- INIT:
  - Counts INIT_CYCLES edges with o_busy=1, then goes to IDLE with o_busy=0.
  - armed is set on any edge where i_cs=1.
- Acceptance at edge E0 requires all of: state=IDLE, i_cs=0, armed=1.
  - Latch write, {i_bank, i_address[ADDR_W-1:0]} and data.
  - Clear armed and o_dataReady.
  - Set o_busy=1 and move to WAIT.
  - If i_address[23:ADDR_W] is nonzero, set o_addrErr. Access proceeds at the wrapped address.
- Re-arm rule: armed sets only on an edge where i_cs=1. Holding i_cs low for many cycles produces exactly one access, and a new request needs i_cs high for at least one edge.
- WAIT: counts LATENCY edges, then goes to ACCESS.
- ACCESS: a one-cycle synchronous RAM operation.
  - Write: commits at this edge.
  - Read: the registered RAM output is loaded into o_dataRead.
  - Then returns to IDLE.
- Timing: o_busy is high for exactly LATENCY+2 clock periods after E0. o_busy=0 and, for reads only, o_dataReady=1 become visible after the same edge. With the default LATENCY=4, busy lasts 6 cycles.
- o_dataReady and o_dataRead hold until the next acceptance. Writes never assert o_dataReady.
- i_cs=0 while o_busy=1 is ignored; there is no queuing. Input changes after acceptance have no effect.
- o_addrErr clears only on reset.
- Reset mid-WAIT or mid-ACCESS: the pending write is not committed and o_dataReady=0. Exception: a write whose ACCESS edge has already passed stays committed.

Optional Feature:
- Macro: MEM_RESPONDER_JITTER_EN.
- Defined:
  - Adds an 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5 on reset. It steps once per acceptance.
  - lfsr[1:0] is added to the WAIT count, so busy lasts LATENCY+2 .. LATENCY+5 cycles.
  - Stresses initiators that assume fixed latency.
- Undefined: no LFSR logic; latency is exactly as above.

Decomposition:
- Package mem_if_pkg holds:
  - the state enum (INIT, IDLE, WAIT, ACCESS) as bit[1:0];
  - MEMIF_ADDR_W=24;
  - the LFSR seed 8'hA5 and tap mask.
- The initiator-side FSM reuses this package.
- Sub-module mem_responder_ram: single-port synchronous block RAM, 2^(ADDR_W+1) x 8, with write-enable and registered read. It keeps the BRAM inference clean.

Test Plan:
- Reset release → o_busy=1 for 16 cycles, then 0. o_dataReady=0, o_dataRead=8'h00, o_addrErr=0.
- Write 8'hAA to 24'h000001, bank 1, with i_cs held low 20 cycles → exactly one RAM write and busy for 6 cycles. Then i_cs=1 for one cycle and read the same address → after 6 cycles o_busy=0, o_dataReady=1, o_dataRead=8'hAA.
- Write 8'h55 to bank 0 / addr 1 and 8'hAA to bank 1 / addr 1 → reads return 8'h55 and 8'hAA respectively. A following write leaves o_dataReady=0.
- Write 8'h3C to 24'h001005 with ADDR_W=12 → o_addrErr=1 (sticky). A read of 24'h000005 returns 8'h3C.
- Pulse i_cs low while busy → ignored. Then assert rst in the 2nd WAIT cycle of a write of 8'h77 to addr 2 → after INIT, a read of addr 2 returns the old value, not 8'h77.
- MEM_RESPONDER_JITTER_EN defined, 64 reads → every busy duration lies in 6..9, at least two distinct durations occur, and all data is correct.
